// File: rtl/nibble_serial_add_ctrl.sv
// Round-robin sequencer that drives one shared 4-bit adder a nibble per clock to build W=4*NIBBLES sums.
// Optional macro SUBTRACT_EN adds per-requester subtract inputs (A - B - cin).
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_cin,
`ifdef SUBTRACT_EN
  input  logic                 req0_sub,
  input  logic                 req1_sub,
`endif
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [4*NIBBLES-1:0] resp_sum,
  output logic                 resp_cout,
  output logic                 resp_id
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cin_q, cin_d;
  logic          sub_q, sub_d;
  logic          id_q, id_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [KW-1:0] k_q, k_d;

  logic          grant_any;
  logic          grant_id;
  logic          sub_in;
  logic [KW+1:0] base;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;

  // With both requesters pending the pointer decides; otherwise the lone requester wins.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? rr_q : req1_valid;

`ifdef SUBTRACT_EN
  assign sub_in = grant_id ? req1_sub : req0_sub;
`else
  assign sub_in = 1'b0;
`endif

  assign base  = {k_q, 2'b00};
  assign nib_a = op_a_q[base +: 4];
  assign nib_b = op_b_q[base +: 4];

  // Ready is masked by rst so a grant cannot be advertised while the block is held in reset.
  assign req0_ready = (state_q == IDLE) & grant_any & ~grant_id & ~rst;
  assign req1_ready = (state_q == IDLE) & grant_any &  grant_id & ~rst;

  assign resp_sum  = sum_q;
  assign resp_cout = cout_q;
  assign resp_id   = id_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sum_d      = sum_q;
    cin_d      = cin_q;
    sub_d      = sub_q;
    id_d       = id_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    k_d        = k_q;
    add_a      = 4'h0;
    add_b      = 4'h0;
    add_cin    = 1'b0;
    resp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          op_a_d  = grant_id ? req1_a : req0_a;
          op_b_d  = grant_id ? req1_b : req0_b;
          cin_d   = grant_id ? req1_cin : req0_cin;
          sub_d   = sub_in;
          id_d    = grant_id;
          rr_d    = ~grant_id;
          k_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Subtraction is A + ~B + ~cin, so only the B nibble and the first carry-in are inverted.
        add_a   = nib_a;
        add_b   = sub_q ? ~nib_b : nib_b;
        add_cin = (k_q == '0) ? (cin_q ^ sub_q) : carry_q;
        sum_d[base +: 4] = add_s;
        carry_d = add_cout;
        k_d     = k_q + 1'b1;
        if (k_q == LAST_K) begin
          cout_d  = add_cout;
          k_d     = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cin_q   <= cin_d;
      sub_q   <= sub_d;
      id_q    <= id_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

endmodule
